// File: rtl/multiplier_result_checker.sv
// rtl/multiplier_result_checker.sv - on-chip golden-product checker for a multiplier under test
//
// Accepts (A, B, P) samples, recomputes A*B with a bit-serial shift-add engine
// (one multiplier bit per cycle), compares against P and keeps saturating
// sample/mismatch counters plus details of the most recent mismatch.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        sample handshake (in_a, in_b, in_p)
//   clear                      synchronous clear of counters, flags and in-flight sample
//   busy                       a sample is being calculated or compared
//   err_valid                  one-cycle pulse on a mismatch
//   err_a/err_b/err_p/
//   err_expected               captured fields of the last mismatching sample
//   sample_count, error_count  saturating counters
//   any_error                  sticky mismatch flag

module multiplier_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2*WIDTH-1:0]   in_p,
    input  logic                 clear,
    output logic                 busy,
    output logic                 err_valid,
    output logic [WIDTH-1:0]     err_a,
    output logic [WIDTH-1:0]     err_b,
    output logic [2*WIDTH-1:0]   err_p,
    output logic [2*WIDTH-1:0]   err_expected,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     error_count,
    output logic                 any_error
);

    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured sample and shift-add engine
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    p_q, p_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Result / statistics registers
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic             any_error_q, any_error_d;
    logic             err_valid_q, err_valid_d;
    logic [WIDTH-1:0] err_a_q, err_a_d;
    logic [WIDTH-1:0] err_b_q, err_b_d;
    logic [PW-1:0]    err_p_q, err_p_d;
    logic [PW-1:0]    err_exp_q, err_exp_d;

    // Control strobes produced by the output process
    logic accept;
    logic do_cmp;
    logic calc_active;
    logic last_bit;
    logic mismatch;

    assign last_bit = (idx_q == IDX_LAST);
    assign mismatch = (acc_q != p_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (clear overrides everything, discarding any
    // sample in flight)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept)   state_d = S_CALC;
                S_CALC:  if (last_bit) state_d = S_CMP;
                S_CMP:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = (state_q == S_IDLE) && !clear;
        busy        = (state_q != S_IDLE);
        accept      = in_valid && in_ready;
        calc_active = (state_q == S_CALC) && !clear;
        do_cmp      = (state_q == S_CMP) && !clear;
    end

    // ------------------------------------------------------------------
    // Datapath: sample capture and shift-add golden product
    // ------------------------------------------------------------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        acc_d = acc_q;
        idx_d = idx_q;
        if (clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (accept) begin
            a_d   = in_a;
            b_d   = in_b;
            p_d   = in_p;
            acc_d = '0;
            idx_d = '0;
        end else if (calc_active) begin
            // Full WIDTH iterations are always run, even for zero operands,
            // so latency is data independent.
            if (b_q[idx_q]) begin
                acc_d = acc_q + (PW'(a_q) << idx_q);
            end
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Comparison, counters and mismatch capture
    // ------------------------------------------------------------------
    always_comb begin
        sample_count_d = sample_count_q;
        error_count_d  = error_count_q;
        any_error_d    = any_error_q;
        err_valid_d    = 1'b0;
        err_a_d        = err_a_q;
        err_b_d        = err_b_q;
        err_p_d        = err_p_q;
        err_exp_d      = err_exp_q;
        if (clear) begin
            sample_count_d = '0;
            error_count_d  = '0;
            any_error_d    = 1'b0;
            err_a_d        = '0;
            err_b_d        = '0;
            err_p_d        = '0;
            err_exp_d      = '0;
        end else if (do_cmp) begin
            if (sample_count_q != CNT_MAX) begin
                sample_count_d = sample_count_q + 1'b1;
            end
            if (mismatch) begin
                if (error_count_q != CNT_MAX) begin
                    error_count_d = error_count_q + 1'b1;
                end
                any_error_d = 1'b1;
                err_valid_d = 1'b1;
                err_a_d     = a_q;
                err_b_d     = b_q;
                err_p_d     = p_q;
                err_exp_d   = acc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count_q <= '0;
            error_count_q  <= '0;
            any_error_q    <= 1'b0;
            err_valid_q    <= 1'b0;
            err_a_q        <= '0;
            err_b_q        <= '0;
            err_p_q        <= '0;
            err_exp_q      <= '0;
        end else begin
            sample_count_q <= sample_count_d;
            error_count_q  <= error_count_d;
            any_error_q    <= any_error_d;
            err_valid_q    <= err_valid_d;
            err_a_q        <= err_a_d;
            err_b_q        <= err_b_d;
            err_p_q        <= err_p_d;
            err_exp_q      <= err_exp_d;
        end
    end

    assign sample_count = sample_count_q;
    assign error_count  = error_count_q;
    assign any_error    = any_error_q;
    assign err_valid    = err_valid_q;
    assign err_a        = err_a_q;
    assign err_b        = err_b_q;
    assign err_p        = err_p_q;
    assign err_expected = err_exp_q;

endmodule

// File: tb/tb_multiplier_result_checker.sv
// tb/tb_multiplier_result_checker.sv - self-checking bench for multiplier_result_checker

module tb_multiplier_result_checker;

    localparam int W  = 8;
    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance (CNT_W = 16)
    logic          in_valid, in_ready, clear, busy, err_valid, any_error;
    logic [W-1:0]  in_a, in_b, err_a, err_b;
    logic [PW-1:0] in_p, err_p, err_expected;
    logic [15:0]   sample_count, error_count;

    // Saturation instance (CNT_W = 4)
    logic          v4, r4, clr4, busy4, ev4, any4;
    logic [W-1:0]  a4, b4, ea4, eb4;
    logic [PW-1:0] p4, ep4, ee4;
    logic [3:0]    sc4, ec4;

    multiplier_result_checker #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .clear(clear), .busy(busy),
        .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_p(err_p),
        .err_expected(err_expected), .sample_count(sample_count),
        .error_count(error_count), .any_error(any_error)
    );

    multiplier_result_checker #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .in_a(a4), .in_b(b4), .in_p(p4), .clear(clr4), .busy(busy4),
        .err_valid(ev4), .err_a(ea4), .err_b(eb4), .err_p(ep4),
        .err_expected(ee4), .sample_count(sc4),
        .error_count(ec4), .any_error(any4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic over the sample stream
    int          m_sc, m_ec;
    logic        m_any;
    logic [7:0]  m_ea, m_eb;
    logic [15:0] m_ep, m_ee;

    task automatic model_clear();
        m_sc = 0; m_ec = 0; m_any = 1'b0;
        m_ea = '0; m_eb = '0; m_ep = '0; m_ee = '0;
    endtask

    task automatic model_sample(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int prod;
        prod = int'(a) * int'(b);
        m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        if (int'(p) != prod) begin
            m_ec  = (m_ec < 65535) ? m_ec + 1 : 65535;
            m_any = 1'b1;
            m_ea  = a; m_eb = b; m_ep = p; m_ee = 16'(prod);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".sample_count"}, sample_count, m_sc);
        chk({tag, ".error_count"}, error_count, m_ec);
        chk({tag, ".any_error"}, any_error, m_any);
        chk({tag, ".err_a"}, err_a, m_ea);
        chk({tag, ".err_b"}, err_b, m_eb);
        chk({tag, ".err_p"}, err_p, m_ep);
        chk({tag, ".err_expected"}, err_expected, m_ee);
    endtask

    // Applies one sample on the main instance; returns err_valid pulse count
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input string tag, output int pulses);
        int guard;
        int cycles;
        bit exp_err;
        exp_err = (int'(p) != int'(a) * int'(b));
        pulses = 0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({tag, ".ready_timeout"}, 0, 1);
        in_a = a; in_b = b; in_p = p; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_sample(a, b, p);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (err_valid) pulses++;
        end while (!in_ready && cycles < 40);
        chk({tag, ".latency"}, cycles, 10);
        chk({tag, ".err_pulses"}, pulses, exp_err);
        chk_model(tag);
        @(negedge clk);
        chk({tag, ".err_valid_drop"}, err_valid, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          err;
        logic [15:0] expected;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pulses;
        int accepts, last_cyc, cyc, injected, guard;
        bit will;
        logic [7:0]  ra, rb;
        logic [15:0] rp;

        tbl[0] = '{a: 8'd3,   b: 8'd1,   p: 16'd3,     err: 0, expected: 16'd3};
        tbl[1] = '{a: 8'd3,   b: 8'd2,   p: 16'd7,     err: 1, expected: 16'd6};
        tbl[2] = '{a: 8'd255, b: 8'd255, p: 16'd65025, err: 0, expected: 16'd65025};
        tbl[3] = '{a: 8'd0,   b: 8'd200, p: 16'd0,     err: 0, expected: 16'd0};
        tbl[4] = '{a: 8'd200, b: 8'd0,   p: 16'd1,     err: 1, expected: 16'd0};
        tbl[5] = '{a: 8'd128, b: 8'd128, p: 16'd16383, err: 1, expected: 16'd16384};

        rst_n = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_p = '0; clear = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; p4 = '0; clr4 = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.busy", busy, 0);
        chk("reset.err_valid", err_valid, 0);
        chk_model("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.in_ready", in_ready, 1);
        chk("post_reset.sample_count", sample_count, 0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i), pulses);
            chk($sformatf("vec%0d.tbl_err", i), pulses, tbl[i].err);
            if (tbl[i].err != 0) chk($sformatf("vec%0d.tbl_expected", i), err_expected, tbl[i].expected);
        end

        // Randomized samples against the model
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rp = 16'(int'(ra) * int'(rb));
            if ($urandom_range(0, 3) == 0) rp = rp ^ 16'(1 << $urandom_range(0, 15));
            send(ra, rb, rp, $sformatf("rnd%0d", i), pulses);
        end

        // in_valid held high: back-to-back accepts every WIDTH+2 cycles
        accepts = 0; last_cyc = -1; cyc = 0; injected = 0; pulses = 0;
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rp = 16'(int'(ra) * int'(rb));
        if ($urandom_range(0, 2) == 0) begin rp = rp + 16'd1; end
        in_a = ra; in_b = rb; in_p = rp; in_valid = 1'b1;
        while (accepts < 20 && cyc < 400) begin
            will = in_ready;
            @(posedge clk);
            cyc++;
            if (will) begin
                accepts++;
                if (int'(rp) != int'(ra) * int'(rb)) injected++;
                model_sample(ra, rb, rp);
                if (last_cyc >= 0) chk("stream.gap", cyc - last_cyc, 10);
                last_cyc = cyc;
            end
            @(negedge clk);
            if (err_valid) pulses++;
            if (will) begin
                if (accepts == 20) begin
                    in_valid = 1'b0;
                end else begin
                    ra = 8'($urandom); rb = 8'($urandom); rp = 16'(int'(ra) * int'(rb));
                    if ($urandom_range(0, 2) == 0) rp = rp + 16'd1;
                    in_a = ra; in_b = rb; in_p = rp;
                end
            end
        end
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
            if (err_valid) pulses++;
        end
        chk("stream.accepts", accepts, 20);
        chk("stream.pulses", pulses, injected);
        chk_model("stream");

        // clear three cycles into CALC
        @(negedge clk);
        in_a = 8'd5; in_b = 8'd5; in_p = 16'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("clear.busy_before", busy, 1);
        clear = 1'b1;
        #1;
        chk("clear.in_ready_low", in_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
        @(negedge clk);
        chk("clear.busy", busy, 0);
        chk("clear.err_valid", err_valid, 0);
        chk_model("clear");
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (err_valid) pulses++;
        end
        chk("clear.no_pulse", pulses, 0);
        chk("clear.sample_count_after", sample_count, 0);
        send(8'd9, 8'd9, 16'd81, "after_clear_ok", pulses);
        send(8'd9, 8'd10, 16'd91, "after_clear_err", pulses);

        // Saturation on the CNT_W=4 instance
        accepts = 0; cyc = 0;
        @(negedge clk);
        a4 = 8'd1; b4 = 8'd1; p4 = 16'd0; v4 = 1'b1;
        while (accepts < 20 && cyc < 400) begin
            will = r4;
            @(posedge clk);
            cyc++;
            if (will) accepts++;
            @(negedge clk);
            if (will && accepts == 20) v4 = 1'b0;
        end
        guard = 0;
        while (!r4 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("sat.accepts", accepts, 20);
        chk("sat.error_count", ec4, 15);
        chk("sat.sample_count", sc4, 15);
        chk("sat.any_error", any4, 1);

        // Asynchronous reset in the middle of CALC
        a4 = 8'd7; b4 = 8'd7; p4 = 16'd0; v4 = 1'b1;
        @(posedge clk);
        #1 v4 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.in_ready", r4, 1);
        chk("async_rst.busy", busy4, 0);
        chk("async_rst.err_valid", ev4, 0);
        chk("async_rst.sample_count", sc4, 0);
        chk("async_rst.error_count", ec4, 0);
        chk("async_rst.any_error", any4, 0);
        chk("async_rst.err_fields", {ea4, eb4, ep4, ee4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ev4) pulses++;
        end
        chk("post_rst.pulses", pulses, 0);
        chk("post_rst.sample_count", sc4, 0);
        chk("post_rst.error_count", ec4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
